param_mux_scan: RTL and testbench

- Parametrised, registered N:1 multiplexer; generalises the lab's fixed 16:1 combinational mux to configurable width and channel count.
- Two modes:
  - Direct mode: registered select, 1-cycle latency.
  - Scan mode: walks all enabled channels in ascending order, emitting one word per valid/ready handshake.
- Sits between the register/ALU operand sources and downstream consumers. Its output stage supports backpressure.

---
 rtl/param_mux_scan.sv | 171 +++++++++++++++++
 tb/tb_param_mux_scan.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_mux_scan.sv
// Registered N:1 mux with direct-select and masked-scan modes.
// Define PARAM_MUX_PARITY_EN to add the out_parity output.
module param_mux_scan #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 16,
  parameter int SEL_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_mask,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    start,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
`ifdef PARAM_MUX_PARITY_EN
  output logic                    out_parity,
`endif
  output logic                    done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIRECT,
    S_SCAN,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [NUM_IN-1:0]  mask_q;
  logic               last_q;
  logic [WIDTH-1:0]   data_q;
  logic [SEL_W-1:0]   ch_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;

  logic               load;
  logic [WIDTH-1:0]   sel_word;
  logic [WIDTH-1:0]   ptr_word;
  logic [WIDTH-1:0]   word_d;
  logic [SEL_W-1:0]   first_d;
  logic [SEL_W-1:0]   next_d;
  logic               next_vld;

  assign load = !valid_q || out_ready;

  // Unselectable indices (>= NUM_IN) fall through to zero.
  always_comb begin
    sel_word = '0;
    ptr_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k))
        sel_word = in_data[k*WIDTH +: WIDTH];
      if (ptr_q == SEL_W'(k))
        ptr_word = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign word_d = (state_q == S_SCAN) ? ptr_word : sel_word;

  // Descending walk so the lowest qualifying index wins.
  always_comb begin
    first_d  = '0;
    next_d   = '0;
    next_vld = 1'b0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (in_mask[k])
        first_d = SEL_W'(k);
      if (mask_q[k] && (SEL_W'(k) > ptr_q)) begin
        next_d   = SEL_W'(k);
        next_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!mode) begin
            state_q <= S_DIRECT;
          end else if (start) begin
            mask_q <= in_mask;
            if (in_mask == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              ptr_q   <= first_d;
              last_q  <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_SCAN;
            end
          end
        end
        S_DIRECT: begin
          if (load) begin
            if (mode) begin
              valid_q <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              data_q  <= word_d;
              ch_q    <= sel;
              valid_q <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          if (load) begin
            if (last_q) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              data_q  <= word_d;
              ch_q    <= ptr_q;
              valid_q <= 1'b1;
              if (next_vld) ptr_q  <= next_d;
              else          last_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef PARAM_MUX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst)
      parity_q <= 1'b0;
    else if (load && !last_q && state_q == S_SCAN)
      parity_q <= ^word_d;
    else if (load && !mode && state_q == S_DIRECT)
      parity_q <= ^word_d;
  end

  assign out_parity = parity_q;
`endif

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_param_mux_scan.sv
// Randomized self-checking bench for param_mux_scan.
// Scan results are scored against a mask-derived channel queue.
module tb_param_mux_scan;

  localparam int W   = 16;
  localparam int N   = 16;
  localparam int S   = 4;
  localparam int N12 = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_mask = '0;
  logic           mode = 1'b1;
  logic [S-1:0]   sel = '0;
  logic           start = 1'b0;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_ch;
  logic           out_valid;
  logic           busy;
  logic           done;

  logic [N12*W-1:0] in_data12 = '0;
  logic [N12-1:0]   in_mask12 = '0;
  logic             mode12 = 1'b0;
  logic [S-1:0]     sel12 = '0;
  logic             start12 = 1'b0;
  logic             ready12 = 1'b1;
  logic [W-1:0]     out_data12;
  logic [S-1:0]     out_ch12;
  logic             out_valid12;
  logic             busy12;
  logic             done12;

`ifdef PARAM_MUX_PARITY_EN
  logic out_parity;
  logic out_parity12;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  param_mux_scan #(.WIDTH(W), .NUM_IN(N), .SEL_W(S)) u_dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_mask(in_mask),
    .mode(mode), .sel(sel), .start(start),
    .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy),
`ifdef PARAM_MUX_PARITY_EN
    .out_parity(out_parity),
`endif
    .done(done)
  );

  param_mux_scan #(.WIDTH(W), .NUM_IN(N12), .SEL_W(S)) u_dut12 (
    .clk(clk), .rst(rst),
    .in_data(in_data12), .in_mask(in_mask12),
    .mode(mode12), .sel(sel12), .start(start12),
    .out_data(out_data12), .out_ch(out_ch12),
    .out_valid(out_valid12), .out_ready(ready12),
    .busy(busy12),
`ifdef PARAM_MUX_PARITY_EN
    .out_parity(out_parity12),
`endif
    .done(done12)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] chw(input logic [N*W-1:0] d, input int k);
    return d[k*W +: W];
  endfunction

  task automatic fill_data;
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    fill_data();
    in_mask = N'($urandom);
    mode = 1'($urandom);
    sel = S'($urandom);
    start = 1'($urandom);
    out_ready = 1'($urandom);
    tick();
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b exp=0", out_valid);
    end
    total++;
    if (out_data !== '0) begin
      bad++; $display("FAIL rst_data got=%h exp=0", out_data);
    end
    total++;
    if (out_ch !== '0) begin
      bad++; $display("FAIL rst_ch got=%0d exp=0", out_ch);
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rst_busy_done got=%b%b exp=00", busy, done);
    end
    total++;
    if (out_valid12 !== 1'b0) begin
      bad++; $display("FAIL rst_valid12 got=%b exp=0", out_valid12);
    end
    mode = 1'b1;
    start = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_quiet got=%b%b exp=00", out_valid, busy);
    end
  endtask

  task automatic test_direct_sweep;
    for (int k = 0; k < N; k++) in_data[k*W +: W] = 16'hA000 + W'(k);
    out_ready = 1'b1;
    mode = 1'b0;
    sel = '0;
    tick();
    for (int s = 0; s < N; s++) begin
      sel = S'(s);
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'hA000 + W'(s) || out_ch !== S'(s)) begin
        bad++;
        $display("FAIL sweep sel=%0d got=%b/%h/%0d exp=1/%h/%0d",
                 s, out_valid, out_data, out_ch, 16'hA000 + W'(s), s);
      end
    end
  endtask

  task automatic test_direct_random;
    logic           ev;
    logic [W-1:0]   ed;
    logic [S-1:0]   ec;
    ev = 1'b1;
    ed = 16'hA00F;
    ec = 4'd15;
    for (int i = 0; i < 60; i++) begin
      fill_data();
      sel = S'($urandom);
      out_ready = ($urandom % 3) != 0;
      start = 1'($urandom);
      if (!ev || out_ready) begin
        ed = chw(in_data, int'(sel));
        ec = sel;
        ev = 1'b1;
      end
      tick();
      total++;
      if (out_valid !== ev || out_data !== ed || out_ch !== ec || busy !== 1'b0) begin
        bad++;
        $display("FAIL direct_rand i=%0d got=%b/%h/%0d/b%b exp=%b/%h/%0d/b0",
                 i, out_valid, out_data, out_ch, busy, ev, ed, ec);
      end
`ifdef PARAM_MUX_PARITY_EN
      total++;
      if (out_parity !== ^ed) begin
        bad++; $display("FAIL direct_parity got=%b exp=%b", out_parity, ^ed);
      end
`endif
    end
    start = 1'b0;
    mode = 1'b1;
    out_ready = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== ed || out_ch !== ec) begin
      bad++;
      $display("FAIL direct_exit_hold got=%b/%h/%0d exp=1/%h/%0d",
               out_valid, out_data, out_ch, ed, ec);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL direct_exit got=%b exp=0", out_valid);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_after_direct got=%b%b exp=00", out_valid, busy);
    end
  endtask

  task automatic test_out_of_range;
    for (int k = 0; k < N12; k++) in_data12[k*W +: W] = W'($urandom);
    sel12 = 4'd13;
    tick();
    total++;
    if (out_valid12 !== 1'b1 || out_data12 !== '0 || out_ch12 !== 4'd13) begin
      bad++;
      $display("FAIL oor13 got=%b/%h/%0d exp=1/0/13", out_valid12, out_data12, out_ch12);
    end
    sel12 = 4'd11;
    tick();
    total++;
    if (out_data12 !== in_data12[11*W +: W] || out_ch12 !== 4'd11) begin
      bad++;
      $display("FAIL top11 got=%h/%0d exp=%h/11", out_data12, out_ch12, in_data12[11*W +: W]);
    end
    sel12 = 4'd15;
    tick();
    total++;
    if (out_data12 !== '0 || out_ch12 !== 4'd15) begin
      bad++; $display("FAIL oor15 got=%h/%0d exp=0/15", out_data12, out_ch12);
    end
  endtask

  // rmode: 0 ready high, 1 random ready, 2 three-cycle stall on ch 5
  task automatic test_scan(input logic [N-1:0] m, input int rmode);
    int   expq[$];
    int   k;
    int   cyc;
    int   stall;
    logic got_done;
    logic r;
    logic acc;
    logic [N*W-1:0] held;
    for (int i = 0; i < N; i++) if (m[i]) expq.push_back(i);
    k = expq.size();
    fill_data();
    held = in_data;
    in_mask = m;
    mode = 1'b1;
    start = 1'b1;
    cyc = 0;
    stall = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 200) begin
      if (rmode == 1) r = 1'($urandom);
      else if (rmode == 2 && out_valid && out_ch == 4'd5 && stall < 3) begin
        r = 1'b0;
        stall++;
      end else r = 1'b1;
      out_ready = r;
      acc = out_valid && r;
      tick();
      cyc++;
      if (acc && expq.size() > 0) void'(expq.pop_front());
      if (done) begin
        got_done = 1'b1;
        total++;
        if (expq.size() != 0 || out_valid !== 1'b0 || busy !== 1'b0) begin
          bad++;
          $display("FAIL scan_done m=%h left=%0d v=%b b=%b exp=0/0/0",
                   m, expq.size(), out_valid, busy);
        end
        if (rmode == 0) begin
          total++;
          if (cyc != ((k == 0) ? 1 : k + 2)) begin
            bad++;
            $display("FAIL scan_latency m=%h got=%0d exp=%0d",
                     m, cyc, (k == 0) ? 1 : k + 2);
          end
        end
      end else begin
        total++;
        if (busy !== (k > 0)) begin
          bad++; $display("FAIL scan_busy m=%h cyc=%0d got=%b exp=%b", m, cyc, busy, k > 0);
        end
        if (out_valid) begin
          total++;
          if (expq.size() == 0) begin
            bad++; $display("FAIL scan_extra m=%h got=ch%0d exp=none", m, out_ch);
          end else if (out_ch !== S'(expq[0]) || out_data !== chw(held, expq[0])) begin
            bad++;
            $display("FAIL scan_word m=%h got=%0d/%h exp=%0d/%h",
                     m, out_ch, out_data, expq[0], chw(held, expq[0]));
          end
`ifdef PARAM_MUX_PARITY_EN
          total++;
          if (out_parity !== ^out_data) begin
            bad++; $display("FAIL scan_parity got=%b exp=%b", out_parity, ^out_data);
          end
`endif
        end
      end
      in_mask = N'($urandom);
      sel = S'($urandom);
      start = (!got_done && busy) ? 1'($urandom) : 1'b0;
    end
    start = 1'b0;
    if (!got_done) begin
      total++;
      bad++;
      $display("FAIL scan_timeout m=%h got=no_done exp=done", m);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL scan_after m=%h got=d%b b%b v%b exp=000", m, done, busy, out_valid);
    end
  endtask

  task automatic test_mid_reset;
    int   n;
    logic hit;
    fill_data();
    in_mask = 16'hFFFF;
    mode = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 20) begin
      tick();
      n++;
      if (out_valid && out_ch == 4'd3) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL midrst_reach got=none exp=ch3");
    end
    rst = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midrst_out got=%b/%h/%0d/%b/%b exp=0/0/0/0/0",
               out_valid, out_data, out_ch, busy, done);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL midrst_quiet i=%0d got=d%b v%b b%b exp=000", i, done, out_valid, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct_sweep();
    test_direct_random();
    test_out_of_range();
    test_scan(16'h8421, 0);
    test_scan(16'h8421, 2);
    test_scan(16'h0000, 0);
    test_scan(16'h0100, 0);
    test_scan(16'h8000, 1);
    test_scan(16'hFFFF, 1);
    for (int i = 0; i < 6; i++) begin
      test_scan(N'($urandom), 0);
      test_scan(N'($urandom), 1);
    end
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
